// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with fixed-priority interrupt trap, MRET, and WFI sleep; trap decision is combinational.
// Build option CSR_COUNTERS_EN adds 64-bit mcycle/minstret (B00/B02/B80/B82).
module csr_trap_unit #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        i_csr_raddr,
  output logic [31:0]        o_csr_rdata,
  input  logic [1:0]         i_csr_op,
  input  logic [11:0]        i_csr_waddr,
  input  logic [31:0]        i_csr_wsrc,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_retire,
  input  logic [31:0]        i_pc_in,
  input  logic               i_mret,
  input  logic               i_wfi,
  output logic               o_trap_take,
  output logic [31:0]        o_trap_pc,
  output logic [31:0]        o_mret_pc,
  output logic               o_wfi_stall
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_SLEEP = 1'b1;

  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [NUM_IRQ-1:0] r_mie_en;
  logic [29:0]        r_mtvec_base;
  logic               r_mtvec_vec;
  logic [29:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [0:0]         r_state;
`ifdef CSR_COUNTERS_EN
  logic [63:0]        r_mcycle;
  logic [63:0]        r_minstret;
`endif

  logic [NUM_IRQ-1:0] w_pend;
  logic               w_any_pend;
  logic [3:0]         w_irq_idx;
  logic [4:0]         w_cause_code;
  logic               w_trap;
  logic [31:0]        w_old;
  logic [31:0]        w_wval;
  logic               w_wen;

  assign w_pend     = i_irq & r_mie_en;
  assign w_any_pend = |w_pend;

  always_comb begin
    w_irq_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) w_irq_idx = 4'(i);
    end
  end

  assign w_cause_code = {1'b1, w_irq_idx};
  assign w_trap       = r_mstatus_mie & w_any_pend & ~i_mret & (i_csr_op == 2'b00);
  assign o_trap_take  = w_trap;
  assign o_trap_pc    = {r_mtvec_base, 2'b00}
                      + (r_mtvec_vec ? {25'd0, w_cause_code, 2'b00} : 32'd0);
  assign o_mret_pc    = {r_mepc, 2'b00};
  assign o_wfi_stall  = (r_state == ST_SLEEP);

  function automatic logic [31:0] csr_rd(input logic [11:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      ADDR_MSTATUS:   v = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
      ADDR_MIE:       v = 32'(r_mie_en) << 16;
      ADDR_MTVEC:     v = {r_mtvec_base, 1'b0, r_mtvec_vec};
      ADDR_MEPC:      v = {r_mepc, 2'b00};
      ADDR_MCAUSE:    v = r_mcause;
      ADDR_MIP:       v = (32'(i_irq) << 16) | {20'd0, w_any_pend, 11'd0};
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    v = r_mcycle[31:0];
      ADDR_MCYCLEH:   v = r_mcycle[63:32];
      ADDR_MINSTRET:  v = r_minstret[31:0];
      ADDR_MINSTRETH: v = r_minstret[63:32];
`endif
      default:        v = 32'd0;
    endcase
    return v;
  endfunction

  assign o_csr_rdata = csr_rd(i_csr_raddr);
  assign w_old       = csr_rd(i_csr_waddr);

  // RS/RC with a zero operand is a pure read and must not disturb the register.
  assign w_wen = (i_csr_op != 2'b00) && !(i_csr_op[1] && (i_csr_wsrc == 32'd0));

  always_comb begin
    case (i_csr_op)
      2'b01:   w_wval = i_csr_wsrc;
      2'b10:   w_wval = w_old | i_csr_wsrc;
      default: w_wval = w_old & ~i_csr_wsrc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_en       <= '0;
      r_mtvec_base   <= MTVEC_RESET[31:2];
      r_mtvec_vec    <= MTVEC_RESET[0];
      r_mepc         <= 30'd0;
      r_mcause       <= 32'd0;
      r_state        <= ST_RUN;
    end else begin
      if (w_wen && i_csr_waddr == ADDR_MSTATUS) begin
        r_mstatus_mie  <= w_wval[3];
        r_mstatus_mpie <= w_wval[7];
      end
      if (w_trap) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (i_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
      if (w_wen && i_csr_waddr == ADDR_MIE) r_mie_en <= w_wval[16 +: NUM_IRQ];
      if (w_wen && i_csr_waddr == ADDR_MTVEC) begin
        r_mtvec_base <= w_wval[31:2];
        // Reserved modes 2/3 leave the current mode in place.
        if (!w_wval[1]) r_mtvec_vec <= w_wval[0];
      end
      if (w_trap) begin
        r_mepc   <= i_pc_in[31:2];
        r_mcause <= {27'h400_0000, w_cause_code};
      end else begin
        if (w_wen && i_csr_waddr == ADDR_MEPC)   r_mepc   <= w_wval[31:2];
        if (w_wen && i_csr_waddr == ADDR_MCAUSE) r_mcause <= w_wval;
      end
      case (r_state)
        ST_RUN:   if (i_wfi && !w_any_pend) r_state <= ST_SLEEP;
        default:  if (w_any_pend) r_state <= ST_RUN;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      if (w_wen && i_csr_waddr == ADDR_MCYCLE)       r_mcycle[31:0]  <= w_wval;
      else if (w_wen && i_csr_waddr == ADDR_MCYCLEH) r_mcycle[63:32] <= w_wval;
      else                                           r_mcycle        <= r_mcycle + 64'd1;
      if (w_wen && i_csr_waddr == ADDR_MINSTRET)       r_minstret[31:0]  <= w_wval;
      else if (w_wen && i_csr_waddr == ADDR_MINSTRETH) r_minstret[63:32] <= w_wval;
      else if (i_retire)                               r_minstret        <= r_minstret + 64'd1;
    end
  end

  logic w_unused;
  assign w_unused = ^i_pc_in[1:0];
`else
  logic w_unused;
  assign w_unused = ^{i_retire, i_pc_in[1:0]};
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed scenarios plus randomized traffic against a word-level model of the CSR/trap rules.
module tb_csr_trap_unit;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   raddr = '0;
  logic [31:0]   rdata;
  logic [1:0]    op = '0;
  logic [11:0]   waddr = '0;
  logic [31:0]   wsrc = '0;
  logic [NI-1:0] irq = '0;
  logic          retire = 1'b0;
  logic [31:0]   pc_in = '0;
  logic          mret = 1'b0;
  logic          wfi = 1'b0;
  logic          trap_take;
  logic [31:0]   trap_pc;
  logic [31:0]   mret_pc;
  logic          wfi_stall;

  always #5 clk = ~clk;

  csr_trap_unit #(.NUM_IRQ(NI), .MTVEC_RESET(32'h0001_0000)) dut (
    .clk(clk), .rst(rst),
    .i_csr_raddr(raddr), .o_csr_rdata(rdata),
    .i_csr_op(op), .i_csr_waddr(waddr), .i_csr_wsrc(wsrc),
    .i_irq(irq), .i_retire(retire), .i_pc_in(pc_in),
    .i_mret(mret), .i_wfi(wfi),
    .o_trap_take(trap_take), .o_trap_pc(trap_pc),
    .o_mret_pc(mret_pc), .o_wfi_stall(wfi_stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: whole-register words as software would see them.
  localparam bit [31:0] MIE_MASK = ((32'd1 << NI) - 32'd1) << 16;
  bit [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
  bit [31:0] n_mstatus, n_mie, n_mtvec, n_mepc, n_mcause;
  bit [63:0] m_cyc, m_ins, n_cyc, n_ins;
  bit        m_sleep, n_sleep;

  task automatic m_reset();
    m_mstatus = 32'h0000_1800; m_mie = 0; m_mtvec = 32'h0001_0000;
    m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0; m_sleep = 0;
  endtask

  function automatic bit [31:0] m_pend();
    return (32'(irq) & (m_mie >> 16));
  endfunction

  function automatic bit [31:0] m_rd(input bit [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (32'(irq) << 16) | ((m_pend() != 0) ? 32'h800 : 32'h0);
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_eval();
    bit [31:0] p, v, old, exp_pc;
    int k;
    bit exp_trap;
    if (rst) m_reset();
    p = m_pend();
    k = 0;
    for (int i = NI - 1; i >= 0; i--) if (p[i]) k = i;
    exp_trap = m_mstatus[3] && (p != 0) && !mret && (op == 2'b00);
    exp_pc = (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * (16 + k)) : 32'h0);
    chk("trap_take", 32'(trap_take), 32'(exp_trap));
    if (exp_trap) chk("trap_pc", trap_pc, exp_pc);
    chk("wfi_stall", 32'(wfi_stall), 32'(m_sleep));
    chk("mret_pc", mret_pc, m_mepc);
    chk("csr_rdata", rdata, m_rd(raddr));

    n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mepc = m_mepc;
    n_mcause = m_mcause; n_cyc = m_cyc + 1; n_ins = m_ins + 64'(retire);
    if (op != 0 && !(op >= 2 && wsrc == 0)) begin
      old = m_rd(waddr);
      v = (op == 1) ? wsrc : (op == 2) ? (old | wsrc) : (old & ~wsrc);
      case (waddr)
        12'h300: n_mstatus = (v & 32'h88) | 32'h1800;
        12'h304: n_mie = v & MIE_MASK;
        12'h305: n_mtvec = (v & ~32'h3) | (v[1] ? (m_mtvec & 32'h3) : (v & 32'h3));
        12'h341: n_mepc = v & ~32'h3;
        12'h342: n_mcause = v;
`ifdef CSR_COUNTERS_EN
        12'hB00: n_cyc = {m_cyc[63:32], v};
        12'hB80: n_cyc = {v, m_cyc[31:0]};
        12'hB02: n_ins = {m_ins[63:32], v};
        12'hB82: n_ins = {v, m_ins[31:0]};
`endif
        default: ;
      endcase
    end
    if (exp_trap) begin
      n_mepc = pc_in & ~32'h3;
      n_mcause = 32'h8000_0000 | 32'(16 + k);
      n_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    end else if (mret) begin
      n_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end
    n_sleep = m_sleep ? (p == 0) : (wfi && p == 0);
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      model_eval();
      @(posedge clk);
      if (rst) m_reset();
      else begin
        m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mepc = n_mepc;
        m_mcause = n_mcause; m_cyc = n_cyc; m_ins = n_ins; m_sleep = n_sleep;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] v);
    op = o; waddr = a; wsrc = v;
    step();
    op = 2'b00;
  endtask

  task automatic rdchk(input string name, input logic [11:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  localparam int NA = 12;
  logic [11:0] addr_tab [NA] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                                 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h123, 12'hF14};

  initial begin
    at_neg();
    chk("rst_trap_take", 32'(trap_take), 32'h0);
    chk("rst_wfi_stall", 32'(wfi_stall), 32'h0);
    chk("rst_mret_pc", mret_pc, 32'h0);
    rdchk("rst_mstatus", 12'h300, 32'h0000_1800);
    rdchk("rst_mtvec", 12'h305, 32'h0001_0000);
    rdchk("rst_mie", 12'h304, 32'h0);
    step();
    rst = 1'b0;

    // Vectored trap and MRET
    csr(2'b01, 12'h305, 32'h0001_0001);
    csr(2'b01, 12'h304, 32'h0003_0000);
    csr(2'b10, 12'h300, 32'h0000_0008);
    pc_in = 32'h200;
    irq = 4'b0011;
    at_neg();
    chk("vec_trap_take", 32'(trap_take), 32'h1);
    chk("vec_trap_pc", trap_pc, 32'h0001_0040);
    step();
    at_neg();
    chk("vec_trap_once", 32'(trap_take), 32'h0);
    rdchk("vec_mcause", 12'h342, 32'h8000_0010);
    rdchk("vec_mepc", 12'h341, 32'h0000_0200);
    rdchk("vec_mstatus", 12'h300, 32'h0000_1880);
    step();
    irq = 4'b0000; mret = 1'b1;
    step();
    mret = 1'b0;
    at_neg();
    rdchk("mret_mstatus", 12'h300, 32'h0000_1888);
    chk("mret_pc", mret_pc, 32'h0000_0200);
    step();

    // Read-modify-write ops
    csr(2'b01, 12'h304, 32'h0);
    csr(2'b10, 12'h304, 32'h0001_0000);
    at_neg();
    rdchk("rs_mie", 12'h304, 32'h0001_0000);
    step();
    csr(2'b11, 12'h304, 32'hFFFF_FFFF);
    at_neg();
    rdchk("rc_mie", 12'h304, 32'h0);
    step();
    csr(2'b10, 12'h304, 32'h0001_0000);
    csr(2'b10, 12'h304, 32'h0);
    at_neg();
    rdchk("rs0_mie", 12'h304, 32'h0001_0000);
    step();
    csr(2'b01, 12'h305, 32'h0002_0003);
    at_neg();
    rdchk("mtvec_mode_keep", 12'h305, 32'h0002_0001);
    step();

    // CSR write colliding with a qualifying irq
    irq = 4'b0001;
    op = 2'b01; waddr = 12'h300; wsrc = 32'h8;
    at_neg();
    chk("coll_trap_deferred", 32'(trap_take), 32'h0);
    step();
    op = 2'b00;
    at_neg();
    chk("coll_trap_next", 32'(trap_take), 32'h1);
    chk("coll_trap_pc", trap_pc, 32'h0002_0040);
    step();
    irq = 4'b0000;

    // WFI sleep and wake with MIE clear
    wfi = 1'b1;
    step();
    wfi = 1'b0;
    at_neg();
    chk("wfi_sleep", 32'(wfi_stall), 32'h1);
    step();
    irq = 4'b0001;
    at_neg();
    chk("wfi_wake_cycle_stall", 32'(wfi_stall), 32'h1);
    chk("wfi_wake_no_trap", 32'(trap_take), 32'h0);
    step();
    at_neg();
    chk("wfi_awake", 32'(wfi_stall), 32'h0);
    chk("wfi_awake_no_trap", 32'(trap_take), 32'h0);
    step();
    wfi = 1'b1;
    step();
    wfi = 1'b0;
    at_neg();
    chk("wfi_nop_pending", 32'(wfi_stall), 32'h0);
    step();
    irq = 4'b0000;

`ifdef CSR_COUNTERS_EN
    csr(2'b01, 12'hB80, 32'h0);
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    at_neg();
    rdchk("cyc_written", 12'hB00, 32'hFFFF_FFFF);
    rdchk("cych_written", 12'hB80, 32'h0);
    step();
    at_neg();
    rdchk("cyc_carry_lo", 12'hB00, 32'h0);
    rdchk("cyc_carry_hi", 12'hB80, 32'h1);
    rdchk("instret_idle", 12'hB02, 32'h0);
    step();
`else
    csr(2'b01, 12'hB00, 32'h5);
    at_neg();
    rdchk("no_cnt_b00", 12'hB00, 32'h0);
    rdchk("no_cnt_b80", 12'hB80, 32'h0);
    step();
`endif

    // Asynchronous reset out of SLEEP
    wfi = 1'b1;
    step();
    wfi = 1'b0;
    at_neg();
    chk("pre_rst_sleep", 32'(wfi_stall), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_wake", 32'(wfi_stall), 32'h0);
    rdchk("async_rst_mstatus", 12'h300, 32'h0000_1800);
    rdchk("async_rst_mtvec", 12'h305, 32'h0001_0000);
    step();
    rst = 1'b0;

    // Randomized traffic
    csr(2'b01, 12'h304, 32'h000F_0000);
    csr(2'b01, 12'h300, 32'h8);
    for (int n = 0; n < 4000; n++) begin
      rst    = ($urandom_range(299) == 0);
      mret   = ($urandom_range(19) == 0);
      wfi    = ($urandom_range(14) == 0);
      op     = (!mret && $urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
      waddr  = addr_tab[$urandom_range(NA - 1)];
      raddr  = addr_tab[$urandom_range(NA - 1)];
      case ($urandom_range(3))
        0:       wsrc = 32'h0;
        1:       wsrc = 32'h1 << $urandom_range(31);
        default: wsrc = $urandom;
      endcase
      if ($urandom_range(3) == 0) irq = NI'($urandom) & NI'($urandom);
      retire = 1'($urandom);
      pc_in  = $urandom;
      step();
    end
    rst = 1'b0; op = 2'b00; mret = 1'b0; wfi = 1'b0; irq = '0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and interrupt/trap controller for the pipelined RV32 core, the successor of the single-interrupt CSR file. It adds up to 16 level-sensitive external interrupt lines with fixed priority, `mcause`, direct/vectored `mtvec`, atomic CSRRW/CSRRS/CSRRC, self-running 64-bit `mcycle`/`minstret` counters, and a WFI sleep state. It sits beside the ID stage for reads and takes writes and trap events from the WB stage.

## Interface
- `NUM_IRQ`, 4: number of external interrupt lines, 1..16.
- `MTVEC_RESET`, 32'h0001_0000: reset value of `mtvec`; bits [1:0] must be 0, so reset mode is direct.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `csr_raddr` in 12: CSR read address.
- `csr_rdata` out 32: combinational read data.
- `csr_op` in 2: WB CSR op: 00 none, 01 RW, 10 RS, 11 RC.
- `csr_waddr` in 12: WB CSR write address.
- `csr_wsrc` in 32: WB operand, rs1 value or zero-extended uimm.
- `irq` in NUM_IRQ: level interrupt requests.
- `retire` in 1: one instruction retired this cycle.
- `pc_in` in 32: PC of the oldest unretired instruction, written to `mepc` on trap.
- `mret` in 1: MRET in WB, one-cycle pulse.
- `wfi` in 1: WFI in WB, one-cycle pulse.
- `trap_take` out 1: trap taken this cycle; pipeline flushes and redirects.
- `trap_pc` out 32: trap target, valid when `trap_take` is 1.
- `mret_pc` out 32: equals `mepc`.
- `wfi_stall` out 1: core is stalled in WFI.

## Operation
- Implemented CSRs:
  - mstatus 300: MIE[3], MPIE[7], MPP[12:11]; MPP is hardwired to 11.
  - mie 304: bits [16+NUM_IRQ-1:16].
  - mtvec 305: base[31:2] and mode[1:0]. A write with mode 2 or 3 updates the base and keeps the old mode.
  - mepc 341: bits [1:0] are hardwired to 0.
  - mcause 342: read/write.
  - mip 344: read-only. mip[16+i] = `irq[i]`; mip[11] = OR of all enabled pending lines.
  - Counters: mcycle B00, minstret B02, mcycleh B80, minstreth B82.
- Unimplemented addresses read 0 and ignore writes. All unimplemented bits read 0.
- Write value:
  - RW writes `csr_wsrc`.
  - RS writes `old | csr_wsrc`.
  - RC writes `old & ~csr_wsrc`.
  - RS/RC with `csr_wsrc == 0` performs no write.
- Pending vector: `pend = mip[16+:NUM_IRQ] & mie[16+:NUM_IRQ]`. The lowest set index `k` wins.
- Trap condition: `trap_take = MIE & |pend & ~mret & (csr_op == 00)`.
- On trap, at the clock edge:
  - `mepc <= pc_in`, `mcause <= 32'h8000_0000 | (16+k)`.
  - `MPIE <= MIE`, `MIE <= 0`.
- Trap target:
  - `trap_pc = base` in direct mode.
  - `trap_pc = base + 4*(16+k)` in vectored mode.
- On MRET: `MIE <= MPIE`, `MPIE <= 1`.
- WFI FSM, states RUN and SLEEP:
  - RUN goes to SLEEP on `wfi` when `|pend` is 0. If `|pend` is 1, WFI acts as a NOP.
  - SLEEP returns to RUN when `|pend` is 1, regardless of MIE.
  - `wfi_stall` is 1 only in SLEEP.
  - A trap can be taken in the wake cycle when MIE is 1.
- Counters (with `CSR_COUNTERS_EN`):
  - mcycle increments every cycle, including in SLEEP.
  - minstret increments when `retire` is 1.
  - Both are 64 bits; the low half carries into the high half.
  - A CSR write to either half in a cycle suppresses that counter's increment in that cycle; the written half takes the written value and the other half holds.

## Timing
- Reset values:
  - mstatus 32'h0000_1800; mtvec `MTVEC_RESET`.
  - mie, mepc, mcause and all counters 0. FSM in RUN.
- Outputs in reset: `trap_take` 0, `wfi_stall` 0, `mret_pc` 0, `csr_rdata` reflects reset state.
- `csr_rdata` is combinational from the current register state, with no WB bypass. A read in the same cycle as a write returns the pre-edge value.
- `trap_take` and `trap_pc` are combinational. State updates at the same rising edge; latency 0 from a qualifying `irq` level to `trap_take`.
- Simultaneous events:
  - CSR write and pending trap in the same cycle: the write commits and the trap is deferred at least one cycle.
  - MRET and pending irq in the same cycle: MRET commits; the trap can fire the next cycle once MIE is 1.
  - `wfi` and `trap_take` in the same cycle: the trap wins and the FSM stays in RUN.
- Counter wrap: `FFFF_FFFF_FFFF_FFFF + 1` wraps to 0.
- A `rst` assertion at any point returns all state to reset values immediately, including SLEEP to RUN.

## Configuration
- `CSR_COUNTERS_EN` defined: the four counter CSRs are implemented as above.
- Not defined: the counters are removed; B00/B02/B80/B82 read 0 and ignore writes, and `retire` is unused.

## Test plan
- Vectored trap:
  - Setup: `mtvec=0x0001_0001`, `mie=0x0003_0000`, MIE=1, `pc_in=0x200`.
  - Stimulus: raise `irq=2'b11`.
  - Expect: `trap_take=1` for one cycle, `trap_pc=0x0001_0040`, `mcause=0x8000_0010`, `mepc=0x200`, MIE=0, MPIE=1.
- MRET: after the trap above, pulse `mret` -> MIE=1, MPIE=1, `mret_pc=0x200`.
- RMW ops:
  - CSRRS 304 with 0x0001_0000 on mie=0 -> mie=0x0001_0000.
  - Then CSRRC with 0xFFFF_FFFF -> mie=0.
  - CSRRS with 0 -> no change.
- WFI:
  - MIE=0, mie[16]=1. Pulse `wfi` -> `wfi_stall=1`.
  - Raise `irq[0]` -> `wfi_stall=0` next edge, `trap_take` stays 0.
- Counter carry:
  - Write mcycle=0xFFFF_FFFF with mcycleh=0.
  - Expect mcycleh=1 and mcycle=0 one cycle after the write.
  - Without `CSR_COUNTERS_EN`, reading B00 returns 0.
- Collision: CSRRW 300 in the same cycle as a qualifying irq -> `trap_take=0` that cycle and asserted the following cycle if MIE is still 1.
